// File: rtl/display_scan_mux.sv
// Display channel multiplexer with manual one-hot selection and timed auto-scan.
// mux_out/ch_idx/out_valid/sel_err are all registered; freeze stalls everything.
module display_scan_mux #(
  parameter int NUM_CH  = 5,
  parameter int DATA_W  = 12,
  parameter int DWELL_W = 16,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     mode,
  input  logic [NUM_CH-1:0]        sel,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     freeze,
  output logic [DATA_W-1:0]        mux_out,
  output logic [IDX_W-1:0]         ch_idx,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_next;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_next;
  logic [DWELL_W-1:0] dwell_last;
  logic [IDX_W-1:0]   idx_next;
  logic               err_next;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_onehot;
  logic [4:0]         sel_ones;
  logic [IDX_W-1:0]   adv_idx;
  logic               adv_found;

  assign fsm_state = state_q;

  // A dwell of zero is treated as one: advance on every edge.
  assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  always_comb begin
    sel_idx  = '0;
    sel_ones = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel[k]) begin
        sel_ones = sel_ones + 5'd1;
        sel_idx  = IDX_W'(k);
      end
    end
    sel_onehot = (sel_ones == 5'd1);
  end

  // First enabled channel strictly above ch_idx, wrapping; the current channel
  // itself is never a candidate, so a lone enabled current channel holds.
  always_comb begin
    int cand;
    cand      = 0;
    adv_idx   = ch_idx;
    adv_found = 1'b0;
    for (int off = 1; off < NUM_CH; off++) begin
      cand = (int'(ch_idx) + off) % NUM_CH;
      if (!adv_found && ch_en[cand]) begin
        adv_found = 1'b1;
        adv_idx   = IDX_W'(cand);
      end
    end
  end

  // The edge's action follows mode; state_q only tells whether SCAN was
  // already running (so entering SCAN always starts with a cleared counter).
  always_comb begin
    state_next = mode ? SCAN : MAN;
    idx_next   = ch_idx;
    cnt_next   = '0;
    err_next   = 1'b0;
    if (!mode) begin
      idx_next = sel_onehot ? sel_idx : '0;
      err_next = !sel_onehot;
    end else if (state_q == SCAN && ch_en != '0) begin
      if (cnt_q >= dwell_last) begin
        if (adv_found) begin
          idx_next = adv_idx;
        end
      end else begin
        cnt_next = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      ch_idx    <= '0;
      mux_out   <= '0;
      sel_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (freeze) begin
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      ch_idx    <= idx_next;
      mux_out   <= ch_data[int'(idx_next)*DATA_W +: DATA_W];
      sel_err   <= err_next;
      out_valid <= (idx_next != ch_idx) || (state_q == INIT);
    end
  end

endmodule
